// File: rtl/wb_mem_pkg.sv
// Shared constants and types for the Wishbone memory responder.
// LFSR seed/taps, pipeline stage record, legal parameter ranges.
package wb_mem_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int LATENCY_MIN     = 1;
    localparam int LATENCY_MAX     = 8;
    localparam int OUTSTANDING_MIN = 1;
    localparam int OUTSTANDING_MAX = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } pipe_stage_t;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/wb_mem_lfsr.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random stall cycles.
module wb_mem_lfsr
    import wb_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {state[14:0], lfsr_feedback(state)};
        end
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 slave memory with fixed-latency in-order acks and a backdoor load port.
// Define WB_MEM_RANDOM_STALL_EN to add LFSR-driven random stall cycles.
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    input  logic        load_en_i,
    input  logic [31:0] load_adr_i,
    input  logic [31:0] load_dat_i
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SH_LEN = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("wb_mem_responder: LATENCY out of range");
        end
        if (MAX_OUTSTANDING < OUTSTANDING_MIN || MAX_OUTSTANDING > OUTSTANDING_MAX) begin : g_bad_outstanding
            $error("wb_mem_responder: MAX_OUTSTANDING out of range");
        end
        if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("wb_mem_responder: DEPTH_WORDS must be a power of two");
        end
    endgenerate

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      rd_word_reg;
    logic [IDX_W-1:0] wb_idx;
    logic [IDX_W-1:0] load_idx;
    logic             accept;
    logic             rand_stall;
    logic             s1_valid_reg;
    logic             s1_read_reg;
    pipe_stage_t      stage1;
    pipe_stage_t      stage_out;
    pipe_stage_t      sh_reg [SH_LEN];
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_bits;

    // Upper address bits alias onto the word array.
    assign wb_idx      = wb_adr_i[IDX_W+1:2];
    assign load_idx    = load_adr_i[IDX_W+1:2];
    assign unused_bits = ^{wb_adr_i[31:IDX_W+2], wb_adr_i[1:0],
                           load_adr_i[31:IDX_W+2], load_adr_i[1:0]};

    // A same-cycle ack frees a slot, so the limit only blocks when nothing retires.
    assign wb_stall_o = ((cnt_reg == CNT_MAX) && !wb_ack_o) || rand_stall;
    assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;

    // Backdoor load is written last so it overrides a colliding bus write.
    always_ff @(posedge clk_i) begin
        rd_word_reg <= mem[wb_idx];
        if (accept && wb_we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (wb_sel_i[k]) begin
                    mem[wb_idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
                end
            end
        end
        if (load_en_i) begin
            mem[load_idx] <= load_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_read_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s1_read_reg  <= accept && !wb_we_i;
        end
    end

    // Stage 1 data is the RAM read register itself; writes carry zero data.
    assign stage1.valid = s1_valid_reg;
    assign stage1.data  = s1_read_reg ? rd_word_reg : 32'h0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SH_LEN; i++) begin
                sh_reg[i] <= '0;
            end
        end else if (!wb_cyc_i) begin
            for (int i = 0; i < SH_LEN; i++) begin
                sh_reg[i] <= '0;
            end
        end else begin
            sh_reg[0] <= stage1;
            for (int i = 1; i < SH_LEN; i++) begin
                sh_reg[i] <= sh_reg[i-1];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat_one
            assign stage_out = stage1;
        end else begin : g_lat_multi
            assign stage_out = sh_reg[SH_LEN-1];
        end
    endgenerate

    assign wb_ack_o = stage_out.valid;
    assign wb_dat_o = stage_out.data;

    always_comb begin
        cnt_next = cnt_reg;
        if (!wb_cyc_i) begin
            cnt_next = '0;
        end else begin
            case ({accept, wb_ack_o})
                2'b10:   cnt_next = cnt_reg + CNT_W'(1);
                2'b01:   cnt_next = cnt_reg - CNT_W'(1);
                default: cnt_next = cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

`ifdef WB_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr;

    wb_mem_lfsr u_lfsr (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (1'b1),
        .state (lfsr_state)
    );

    assign rand_stall  = (lfsr_state[1:0] == 2'b00);
    assign unused_lfsr = ^lfsr_state[15:2];
`else
    assign rand_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_wb_mem_responder;

    localparam int LAT   = 4;
    localparam int MAXO  = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_i, wb_dat_i, load_adr_i, load_dat_i;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, load_en_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_stall_o;

    always #5 clk = ~clk;

    wb_mem_responder #(
        .DEPTH_WORDS     (DEPTH),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .load_en_i  (load_en_i),
        .load_adr_i (load_adr_i),
        .load_dat_i (load_dat_i)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          kind;   // 0 load only, 1 write, 2 read
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          ld;
        logic [31:0] ladr;
        logic [31:0] ldat;
        logic [31:0] exp;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc_no = 0;
    int          stall_seen = 0;
    resp_t       q[$];
    logic [31:0] mm [DEPTH];
    bit          pend_use = 0;
    logic [31:0] pend_exp = 0;
    vec_t        tbl[$];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic vec_t mk(input int kind, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input bit ld, input logic [31:0] ladr,
                                input logic [31:0] ldat, input logic [31:0] exp);
        vec_t v;
        v.kind = kind; v.adr = adr; v.dat = dat; v.sel = sel;
        v.ld = ld; v.ladr = ladr; v.ldat = ldat; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc_no, got, want);
        end
    endtask

    // Called at a falling edge with inputs applied; checks this cycle, updates the model, advances.
    task automatic step();
        bit    exp_ack, exp_stall, acc;
        resp_t r;
        int    w;
        #4;
        exp_ack   = (q.size() > 0) && (q[0].due == cyc_no);
        exp_stall = (q.size() == MAXO) && !exp_ack;
        chk("ack", {31'b0, wb_ack_o}, {31'b0, exp_ack});
        if (exp_ack) begin
            r = q.pop_front();
            if (wb_ack_o === 1'b1) chk("rdata", wb_dat_o, r.data);
        end
`ifdef WB_MEM_RANDOM_STALL_EN
        if (exp_stall) chk("stall_limit", {31'b0, wb_stall_o}, 32'd1);
`else
        chk("stall", {31'b0, wb_stall_o}, {31'b0, exp_stall});
`endif
        if (wb_stall_o === 1'b1) stall_seen++;
        acc = wb_cyc_i && wb_stb_i && (wb_stall_o === 1'b0);
        if (acc) begin
            w     = widx(wb_adr_i);
            r.due = cyc_no + LAT;
            if (wb_we_i) r.data = 32'h0;
            else r.data = pend_use ? pend_exp : mm[w];
            q.push_back(r);
            pend_use = 0;
            $display("cyc %0d req we=%0b adr=%h dat=%h sel=%h", cyc_no, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i);
            if (wb_we_i) begin
                for (int k = 0; k < 4; k++)
                    if (wb_sel_i[k]) mm[w][8*k +: 8] = wb_dat_i[8*k +: 8];
            end
        end
        if (load_en_i) mm[widx(load_adr_i)] = load_dat_i;
        if (!wb_cyc_i) q.delete();
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic issue(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit ld, input logic [31:0] ladr,
                         input logic [31:0] ldat, input bit use_exp, input logic [31:0] exp);
        int n = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b0; load_en_i = 1'b0;
        while (wb_stall_o !== 1'b0 && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) begin
            n_vec++; n_bad++;
            $display("FAIL issue_timeout cyc=%0d got=stalled want=accept", cyc_no);
            return;
        end
        wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        load_en_i = ld; load_adr_i = ladr; load_dat_i = ldat;
        pend_use = use_exp && !we; pend_exp = exp;
        step();
        wb_stb_i = 1'b0; wb_we_i = 1'b0; load_en_i = 1'b0; pend_use = 0;
    endtask

    task automatic drain();
        int n = 0;
        wb_stb_i = 1'b0; load_en_i = 1'b0;
        while (q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_left", q.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b0; wb_adr_i = 0; wb_dat_i = 0; wb_we_i = 0; wb_sel_i = 0;
        wb_stb_i = 0; wb_cyc_i = 0; load_en_i = 0; load_adr_i = 0; load_dat_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_stall", {31'b0, wb_stall_o}, 32'd0);
        rst_i = 1'b1;
        wb_cyc_i = 1'b1;

        tbl.push_back(mk(0, 32'h0,       32'h00000013, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 32'h0,       32'h0,        4'hF, 0, 0, 0, 32'h00000013));
        tbl.push_back(mk(0, 32'h8,       32'h11223344, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h8,       32'hDEADBEEF, 4'b0101, 0, 0, 0, 0));
        tbl.push_back(mk(2, 32'h8,       32'h0,        4'hF, 0, 0, 0, 32'h11AD33EF));
        tbl.push_back(mk(2, 32'h1000,    32'h0,        4'hF, 0, 0, 0, 32'h00000013));
        tbl.push_back(mk(0, 32'h10,      32'hCAFEF00D, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h10,      32'h01020304, 4'hF, 1, 32'h10, 32'hA5A5A5A5, 0));
        tbl.push_back(mk(2, 32'h10,      32'h0,        4'hF, 0, 0, 0, 32'hA5A5A5A5));
        tbl.push_back(mk(0, 32'h14,      32'h55667788, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h14,      32'hFFFFFFFF, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 32'h14,      32'h0,        4'hF, 0, 0, 0, 32'h55667788));
        tbl.push_back(mk(0, 32'h18,      32'h00000000, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h18,      32'hAB000000, 4'b1000, 0, 0, 0, 0));
        tbl.push_back(mk(2, 32'h18,      32'h0,        4'hF, 0, 0, 0, 32'hAB000000));
        tbl.push_back(mk(0, 32'h20,      32'h00000001, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 32'h20,      32'h0,        4'hF, 1, 32'h20, 32'h00000002, 32'h00000001));
        tbl.push_back(mk(2, 32'h20,      32'h0,        4'hF, 0, 0, 0, 32'h00000002));
        tbl.push_back(mk(1, 32'h24,      32'h12345678, 4'hF, 0, 0, 0, 0));
        tbl.push_back(mk(2, 32'h7FFFF024, 32'h0,       4'hF, 0, 0, 0, 32'h12345678));

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].kind)
                0: begin
                    wb_cyc_i = 1'b1; wb_stb_i = 1'b0;
                    load_en_i = 1'b1; load_adr_i = tbl[i].adr; load_dat_i = tbl[i].dat;
                    step();
                    load_en_i = 1'b0;
                end
                1: issue(1, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].ld, tbl[i].ladr, tbl[i].ldat, 0, 0);
                default: issue(0, tbl[i].adr, 0, 4'hF, tbl[i].ld, tbl[i].ladr, tbl[i].ldat, 1, tbl[i].exp);
            endcase
        end
        drain();

        // Four back-to-back reads against the outstanding limit.
        issue(0, 32'h0,  0, 4'hF, 0, 0, 0, 0, 0);
        issue(0, 32'h8,  0, 4'hF, 0, 0, 0, 0, 0);
        issue(0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0);
        issue(0, 32'h14, 0, 4'hF, 0, 0, 0, 0, 0);
        drain();

        // Abort: drop cyc with two reads in flight.
        issue(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 0);
        issue(0, 32'h8, 0, 4'hF, 0, 0, 0, 0, 0);
        wb_cyc_i = 1'b0;
        repeat (8) step();
        issue(0, 32'h14, 0, 4'hF, 0, 0, 0, 1, 32'h55667788);
        drain();

        // Asynchronous reset while an ack is on the bus.
        issue(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 0);
        issue(0, 32'h8, 0, 4'hF, 0, 0, 0, 0, 0);
        n = 0;
        while (!(q.size() > 0 && q[0].due == cyc_no) && n < 20) begin
            step();
            n++;
        end
        chk("ack_before_rst", {31'b0, wb_ack_o}, 32'd1);
        #1 rst_i = 1'b0;
        #1;
        chk("rst_async_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("rst_async_dat", wb_dat_o, 32'd0);
        chk("rst_async_stall", {31'b0, wb_stall_o}, 32'd0);
        q.delete();
        @(negedge clk);
        cyc_no++;
        rst_i = 1'b1;
        issue(0, 32'h8, 0, 4'hF, 0, 0, 0, 1, 32'h11AD33EF);
        drain();

        // Random traffic over a preloaded 64-word window with aliased upper address bits.
        wb_cyc_i = 1'b1;
        for (int w = 0; w < 64; w++) begin
            load_en_i = 1'b1; load_adr_i = w * 4; load_dat_i = $urandom;
            step();
        end
        load_en_i = 1'b0;
        stall_seen = 0;
        for (int i = 0; i < 300; i++) begin
            wb_stb_i   = ($urandom_range(3) != 0);
            wb_we_i    = ($urandom_range(4) == 0);
            wb_adr_i   = ($urandom & 32'hFFFF_F000) | ($urandom_range(63) << 2) | $urandom_range(3);
            wb_dat_i   = $urandom;
            wb_sel_i   = 4'($urandom_range(15));
            load_en_i  = ($urandom_range(7) == 0);
            load_adr_i = $urandom_range(63) << 2;
            load_dat_i = $urandom;
            step();
        end
        wb_stb_i = 1'b0; wb_we_i = 1'b0; load_en_i = 1'b0;
        drain();
        chk("stall_observed", {31'b0, (stall_seen > 0)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
